// File: rtl/alu_md_pkg.sv
// Shared encodings for the EX-stage ALU control and the multiply/divide unit:
// ALU control codes, ALUOp/funct codes and the MDU state type.
package alu_md_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_SRL = 5'b11000;
  localparam logic [4:0] ALU_SRA = 5'b11001;
  localparam logic [4:0] ALU_MOV = 5'b11010;

  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_OR    = 3'b010;
  localparam logic [2:0] AOP_XOR   = 3'b011;
  localparam logic [2:0] AOP_RTYPE = 3'b100;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_MOV   = 6'h0B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_ITER = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Funct codes that touch HI/LO (moves plus mul/div).
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide datapath on operand magnitudes: shift-add multiply
// or restoring divide, STEP_BITS result bits per step, N = DATA_W/STEP_BITS steps.
module md_iter_core
  import alu_md_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  load_div,
  input  logic [DATA_W-1:0]     load_a,
  input  logic [DATA_W-1:0]     load_b,
  output logic                  last,
  output logic [2*DATA_W-1:0]   acc
);

  localparam int N     = DATA_W / STEP_BITS;
  localparam int CNT_W = $clog2(N + 1);

  // acc holds {partial product, unconsumed multiplier} or {remainder, dividend/quotient}.
  logic [DATA_W-1:0]           m;
  logic [CNT_W-1:0]            cnt;
  logic                        is_div;
  logic [2*DATA_W-1:0]         acc_nxt;
  logic [DATA_W+STEP_BITS-1:0] sum;
  logic [DATA_W:0]             rs;
  logic [DATA_W-1:0]           r;
  logic [DATA_W-1:0]           q;

  assign last = (cnt == CNT_W'(1));

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch;
  // blocking assignments here are intentional, each loop pass builds on the previous one.
  always_comb begin
    acc_nxt = acc;
    sum     = '0;
    rs      = '0;
    r       = acc[2*DATA_W-1:DATA_W];
    q       = acc[DATA_W-1:0];
    if (is_div) begin
      for (int k = 0; k < STEP_BITS; k++) begin
        rs = {r, q[DATA_W-1]};
        q  = {q[DATA_W-2:0], 1'b0};
        if (rs >= {1'b0, m}) begin
          rs   = rs - {1'b0, m};
          q[0] = 1'b1;
        end
        r = rs[DATA_W-1:0];
      end
      acc_nxt = {r, q};
    end else begin
      sum = {{STEP_BITS{1'b0}}, acc[2*DATA_W-1:DATA_W]};
      for (int k = 0; k < STEP_BITS; k++) begin
        if (acc[k]) sum = sum + ({{STEP_BITS{1'b0}}, m} << k);
      end
      acc_nxt = {sum, acc[DATA_W-1:STEP_BITS]};
    end
  end

  // NOTE: state uses non-blocking assignments only, and every register (datapath included)
  // is cleared by reset so a mid-operation reset leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      m      <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
    end else if (load) begin
      acc    <= {{DATA_W{1'b0}}, (load_div ? load_a : load_b)};
      m      <= load_div ? load_b : load_a;
      cnt    <= CNT_W'(N);
      is_div <= load_div;
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_md_ctrl.sv
// EX-stage ALU control decode plus the HI/LO multiply/divide unit: sequencing,
// sign fix-up, HI/LO moves and the stall toward the hazard unit.
module alu_md_ctrl
  import alu_md_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [4:0]        ALUCtl,
  output logic              Sign,
  output logic              stall,
  output logic              md_busy,
  output logic              md_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mf_data
);

  md_state_t           state;
  logic                hilo_op;
  logic                md_start;
  logic                accept;
  logic                op_signed;
  logic                div_op;
  logic                div0;
  logic                neg_q;
  logic                neg_r;
  logic                core_last;
  logic [2*DATA_W-1:0] core_acc;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  always_comb begin
    ALUCtl = ALU_ADD;
    case (ALUOp[2:0])
      AOP_ADD: ALUCtl = ALU_ADD;
      AOP_SUB: ALUCtl = ALU_SUB;
      AOP_OR:  ALUCtl = ALU_OR;
      AOP_XOR: ALUCtl = ALU_XOR;
      AOP_RTYPE: begin
        case (Funct)
          F_SLL:          ALUCtl = ALU_SLL;
          F_SRL, F_SRLV:  ALUCtl = ALU_SRL;
          F_SRA:          ALUCtl = ALU_SRA;
          F_MOV:          ALUCtl = ALU_MOV;
          F_ADD, F_ADDU:  ALUCtl = ALU_ADD;
          F_SUB, F_SUBU:  ALUCtl = ALU_SUB;
          F_AND:          ALUCtl = ALU_AND;
          F_OR:           ALUCtl = ALU_OR;
          F_XOR:          ALUCtl = ALU_XOR;
          F_SLT, F_SLTU:  ALUCtl = ALU_SLT;
          default:        ALUCtl = ALU_ADD;
        endcase
      end
      default: ALUCtl = ALU_ADD;
    endcase
  end

  assign Sign      = (ALUOp[2:0] == AOP_OR) ? ~Funct[0] : ~ALUOp[3];
  assign hilo_op   = in_valid && (ALUOp[2:0] == AOP_RTYPE) && is_hilo_funct(Funct);
  assign md_start  = hilo_op && (Funct[5:2] == 4'b0110);
  assign accept    = md_start && !md_busy;
  assign op_signed = ~Funct[0];
  assign stall     = hilo_op && md_busy;
  assign mf_data   = (hilo_op && Funct == F_MFHI) ? hi :
                     (hilo_op && Funct == F_MFLO) ? lo : '0;

  md_iter_core #(
    .DATA_W    (DATA_W),
    .STEP_BITS (STEP_BITS)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state == MD_ITER),
    .load_div (Funct[1]),
    .load_a   (mag(op_a, op_signed)),
    .load_b   (mag(op_b, op_signed)),
    .last     (core_last),
    .acc      (core_acc)
  );

  // Divide by zero overrides the quotient only; the remainder path already yields op_a.
  always_comb begin
    prod = neg_q ? -core_acc : core_acc;
    quot = core_acc[DATA_W-1:0];
    rem  = core_acc[2*DATA_W-1:DATA_W];
    if (div_op) begin
      fix_lo = div0 ? '1 : (neg_q ? -quot : quot);
      fix_hi = neg_r ? -rem : rem;
    end else begin
      fix_lo = prod[DATA_W-1:0];
      fix_hi = prod[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      md_busy <= 1'b0;
      md_done <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      div_op  <= 1'b0;
      div0    <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            state   <= MD_ITER;
            md_busy <= 1'b1;
            div_op  <= Funct[1];
            div0    <= Funct[1] && (op_b == '0);
            neg_q   <= op_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            neg_r   <= op_signed && op_a[DATA_W-1];
          end else if (hilo_op && Funct == F_MTHI) begin
            hi <= op_a;
          end else if (hilo_op && Funct == F_MTLO) begin
            lo <= op_a;
          end
        end
        MD_ITER: begin
          if (core_last) state <= MD_FIX;
        end
        MD_FIX: begin
          hi      <= fix_hi;
          lo      <= fix_lo;
          state   <= MD_IDLE;
          md_busy <= 1'b0;
          md_done <= 1'b1;
        end
        default: begin
          state   <= MD_IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Directed bench for alu_md_ctrl: two instances (1 and 2 bits per step) share stimulus;
// a scoreboard of expected {HI,LO} is filled at issue and drained on md_done.
module tb_alu_md_ctrl;
  import alu_md_pkg::*;

  localparam int W  = 32;
  localparam int NA = 32;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [3:0]    ALUOp;
  logic [5:0]    Funct;
  logic [W-1:0]  op_a, op_b;
  logic [4:0]    ctl_a, ctl_b;
  logic          sign_a, sign_b, stall_a, stall_b, busy_a, busy_b, done_a, done_b;
  logic [W-1:0]  hi_a, lo_a, mf_a, hi_b, lo_b, mf_b;

  int            checks = 0;
  int            failures = 0;
  logic [63:0]   q_a[$];
  logic [63:0]   q_b[$];
  int            first_a, first_b, pulses_a, pulses_b;
  logic [63:0]   exp_v;

  alu_md_ctrl #(.DATA_W(W), .STEP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUOp(ALUOp), .Funct(Funct),
    .op_a(op_a), .op_b(op_b), .ALUCtl(ctl_a), .Sign(sign_a), .stall(stall_a),
    .md_busy(busy_a), .md_done(done_a), .hi(hi_a), .lo(lo_a), .mf_data(mf_a));

  alu_md_ctrl #(.DATA_W(W), .STEP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUOp(ALUOp), .Funct(Funct),
    .op_a(op_a), .op_b(op_b), .ALUCtl(ctl_b), .Sign(sign_b), .stall(stall_b),
    .md_busy(busy_b), .md_done(done_b), .hi(hi_b), .lo(lo_b), .mf_data(mf_b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v; ALUOp = op; Funct = f; op_a = a; op_b = b;
  endtask

  // Reference {HI,LO} from wide integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint xa, xb, p, q, r;
    xa = f[0] ? longint'({32'b0, a}) : longint'($signed(a));
    xb = f[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!f[1]) begin
      p = xa * xb;
      return p;
    end
    if (xb == 0) return {a, 32'hFFFF_FFFF};
    q = xa / xb;
    r = xa % xb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic mon_begin();
    first_a = 0; first_b = 0; pulses_a = 0; pulses_b = 0;
  endtask

  task automatic mon_step(input int i);
    if (done_a) begin
      pulses_a++;
      if (first_a == 0) begin
        first_a = i;
        check("sb_depth_a", 64'(q_a.size()), 64'd1);
        if (q_a.size() != 0) begin
          exp_v = q_a.pop_front();
          check("hilo_a", {hi_a, lo_a}, exp_v);
        end
      end
    end
    if (done_b) begin
      pulses_b++;
      if (first_b == 0) begin
        first_b = i;
        check("sb_depth_b", 64'(q_b.size()), 64'd1);
        if (q_b.size() != 0) begin
          exp_v = q_b.pop_front();
          check("hilo_b", {hi_b, lo_b}, exp_v);
        end
      end
    end
  endtask

  task automatic mon_end();
    check("latency_a", 64'(first_a), 64'(NA + 1));
    check("latency_b", 64'(first_b), 64'(NB + 1));
    check("done_pulses_a", 64'(pulses_a), 64'd1);
    check("done_pulses_b", 64'(pulses_b), 64'd1);
    check("busy_end_a", 64'(busy_a), 64'd0);
    check("busy_end_b", 64'(busy_b), 64'd0);
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    mon_begin();
    q_a.push_back(model(f, a, b));
    q_b.push_back(model(f, a, b));
    @(negedge clk);
    drive(1'b1, 4'b0100, f, a, b);
    #1 check("accept_nostall", 64'(stall_a), 64'd0);
    @(negedge clk);
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
    check("busy_first_a", 64'(busy_a), 64'd1);
    check("busy_first_b", 64'(busy_b), 64'd1);
    for (int i = 1; i <= NA + 4; i++) begin
      @(negedge clk);
      mon_step(i);
    end
    mon_end();
  endtask

  task automatic reset_mid(input int edges);
    @(negedge clk);
    drive(1'b1, 4'b0100, F_MULT, 32'd7, 32'd9);
    @(negedge clk);
    drive(1'b1, 4'b0100, F_MFHI, '0, '0);
    repeat (edges) @(negedge clk);
    check("busy_before_rst_a", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_hilo_a", {hi_a, lo_a}, 64'd0);
    check("rst_hilo_b", {hi_b, lo_b}, 64'd0);
    check("rst_busy", {62'd0, busy_a, busy_b}, 64'd0);
    check("rst_done", {62'd0, done_a, done_b}, 64'd0);
    check("rst_stall", {62'd0, stall_a, stall_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
  endtask

  logic [10:0] tbl [17] = '{
    {6'h00, 5'b10000}, {6'h02, 5'b11000}, {6'h06, 5'b11000}, {6'h03, 5'b11001},
    {6'h0B, 5'b11010}, {6'h20, 5'b00010}, {6'h21, 5'b00010}, {6'h22, 5'b00110},
    {6'h23, 5'b00110}, {6'h24, 5'b00000}, {6'h25, 5'b00001}, {6'h26, 5'b01101},
    {6'h2A, 5'b00111}, {6'h2B, 5'b00111}, {6'h10, 5'b00010}, {6'h18, 5'b00010},
    {6'h3F, 5'b00010}};
  logic [8:0] aop_tbl [6] = '{
    {4'b0000, 5'b00010}, {4'b0001, 5'b00110}, {4'b0010, 5'b00001},
    {4'b0011, 5'b01101}, {4'b0101, 5'b00010}, {4'b0111, 5'b00010}};

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
    #2;
    check("reset_hilo_a", {hi_a, lo_a}, 64'd0);
    check("reset_hilo_b", {hi_b, lo_b}, 64'd0);
    check("reset_flags", {60'd0, busy_a, done_a, busy_b, done_b}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep.
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 4'b0100, tbl[i][10:5], '0, '0);
      #1;
      check($sformatf("ctl_funct_%02h", tbl[i][10:5]), 64'(ctl_a), 64'(tbl[i][4:0]));
      check($sformatf("ctl_funct_%02h_b", tbl[i][10:5]), 64'(ctl_b), 64'(tbl[i][4:0]));
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, aop_tbl[i][8:5], 6'h24, '0, '0);
      #1 check($sformatf("ctl_aluop_%0d", i), 64'(ctl_a), 64'(aop_tbl[i][4:0]));
    end
    drive(1'b1, 4'b0010, 6'h21, '0, '0);
    #1 check("sign_or_f21", 64'(sign_a), 64'd0);
    drive(1'b1, 4'b0010, 6'h20, '0, '0);
    #1 check("sign_or_f20", 64'(sign_a), 64'd1);
    drive(1'b1, 4'b1000, 6'h20, '0, '0);
    #1 check("sign_unsigned", 64'(sign_a), 64'd0);
    drive(1'b1, 4'b0000, 6'h20, '0, '0);
    #1 check("sign_signed", 64'(sign_a), 64'd1);
    drive(1'b1, 4'b0100, F_ADD, 32'h55, '0);
    #1 check("mf_zero_nonmf", {32'd0, mf_a}, 64'd0);
    @(negedge clk);
    drive(1'b0, 4'b0000, 6'h00, '0, '0);

    // Multiply.
    issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_lo", {32'd0, lo_a}, 64'hFFFF_FFEB);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F_MULT, 32'h8000_0000, 32'h8000_0000);
    issue(F_MULT, 32'h1234_5678, 32'hFEDC_BA98);

    // Divide, including divide by zero and MIN/-1.
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_hi", {32'd0, hi_a}, 64'hFFFF_FFFF);
    issue(F_DIVU, 32'd7, 32'd0);
    issue(F_DIV, 32'hFFFF_FFFB, 32'd0);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(F_DIVU, 32'hFFFF_FFFF, 32'd10);
    issue(F_DIV, 32'd100, 32'hFFFF_FFF9);

    // MFLO one cycle behind MULT, with an ADD slipped in.
    mon_begin();
    q_a.push_back(model(F_MULT, 32'd5, 32'hFFFF_FFF7));
    q_b.push_back(model(F_MULT, 32'd5, 32'hFFFF_FFF7));
    @(negedge clk);
    drive(1'b1, 4'b0100, F_MULT, 32'd5, 32'hFFFF_FFF7);
    @(negedge clk);
    drive(1'b1, 4'b0100, F_MFLO, '0, '0);
    #1 check("mflo_stall_0", {62'd0, stall_a, stall_b}, 64'd3);
    for (int i = 1; i <= NA + 3; i++) begin
      @(negedge clk);
      mon_step(i);
      if (i == 5) drive(1'b1, 4'b0000, F_ADD, '0, '0);
      else        drive(1'b1, 4'b0100, F_MFLO, '0, '0);
      #1;
      check($sformatf("mflo_stall_a_%0d", i), 64'(stall_a), 64'((i < NA + 1) && (i != 5)));
      check($sformatf("mflo_stall_b_%0d", i), 64'(stall_b), 64'((i < NB + 1) && (i != 5)));
      if (i == 5) check("add_between_ctl", 64'(ctl_a), 64'(ALU_ADD));
      if (i == NA + 1) check("mflo_data_a", {32'd0, mf_a}, 64'hFFFF_FFD3);
      if (i == NB + 1) check("mflo_data_b", {32'd0, mf_b}, 64'hFFFF_FFD3);
    end
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
    mon_end();

    // MTHI then MFHI; MTLO while busy.
    @(negedge clk);
    drive(1'b1, 4'b0100, F_MTHI, 32'h1234, '0);
    #1 check("mthi_nostall", 64'(stall_a), 64'd0);
    @(negedge clk);
    check("mthi_hi_a", {32'd0, hi_a}, 64'h1234);
    check("mthi_hi_b", {32'd0, hi_b}, 64'h1234);
    drive(1'b1, 4'b0100, F_MFHI, '0, '0);
    #1;
    check("mfhi_data", {32'd0, mf_a}, 64'h1234);
    check("mfhi_nostall", 64'(stall_a), 64'd0);
    mon_begin();
    q_a.push_back(model(F_MULT, 32'd2, 32'd3));
    q_b.push_back(model(F_MULT, 32'd2, 32'd3));
    @(negedge clk);
    drive(1'b1, 4'b0100, F_MULT, 32'd2, 32'd3);
    @(negedge clk);
    drive(1'b1, 4'b0100, F_MTLO, 32'hABCD, '0);
    for (int i = 1; i <= NA + 3; i++) begin
      @(negedge clk);
      mon_step(i);
      if (i == NA + 2) check("mtlo_landed_a", {32'd0, lo_a}, 64'hABCD);
      #1 check($sformatf("mtlo_stall_a_%0d", i), 64'(stall_a), 64'(i < NA + 1));
    end
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
    check("mtlo_landed_b", {32'd0, lo_b}, 64'hABCD);
    mon_end();

    // Reset in the middle of an operation, then a clean multiply.
    reset_mid(NB - 10);
    reset_mid(NA - 10);
    q_a.delete();
    q_b.delete();
    issue(F_MULT, 32'd2, 32'd3);
    check("post_rst_lo_a", {32'd0, lo_a}, 64'd6);
    check("post_rst_lo_b", {32'd0, lo_b}, 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
